vend_dispense_arbiter: RTL

- Shares one physical dispense motor and one product stock counter among NUM_REQ vending front-end FSMs.
- Each front-end raises a vend request once it has collected payment; this block grants requests round-robin and runs the motor for a fixed time.
- On completion it acknowledges the requester. If stock is empty it refuses the request so the requester can return the money.
- Sits between the per-channel coin/vend FSMs and the motor driver.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_dispense_arbiter_if.sv | 32 +++
 rtl/vend_rr_pick.sv | 29 ++
 rtl/vend_dispense_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vend dispense arbiter and the
// per-channel coin/vend front-ends.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Coin codes exchanged with the front-end FSMs
  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_5    = 2'd1;
  localparam logic [1:0] COIN_10   = 2'd2;
  localparam logic [1:0] COIN_25   = 2'd3;

  localparam int MOTOR_CYCLES_DEF = 8;
  localparam int STOCK_INIT_DEF   = 15;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/vend_dispense_arbiter_if.sv
// Request/response bundle between the vend front-ends (master) and the
// dispense arbiter (slave).
interface vend_dispense_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int STOCK_W = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  // Handshake: req[i] is a level held by front-end i until it sees a
  // one-cycle ack[i] (vend done) or nak[i] (sold out), and is dropped in
  // the following cycle; at most one ack/nak bit is high per cycle.
  logic [NUM_REQ-1:0] req;
  logic               restock;
  logic [NUM_REQ-1:0] ack;
  logic [NUM_REQ-1:0] nak;
  logic               motor_on;
  logic               busy;
  logic [IDX_W-1:0]   grant_id;
  logic [STOCK_W-1:0] stock;
  logic               sold_out;

  modport master (
    output req, restock,
    input  ack, nak, motor_on, busy, grant_id, stock, sold_out
  );

  modport slave (
    input  req, restock,
    output ack, nak, motor_on, busy, grant_id, stock, sold_out
  );

endinterface

// File: rtl/vend_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping past NUM_REQ-1 back to 0.
module vend_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is the last write
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter sharing one dispense motor and one stock counter
// among NUM_REQ vend front-ends.
module vend_dispense_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MOTOR_CYCLES = MOTOR_CYCLES_DEF,
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = STOCK_INIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  vend_dispense_arbiter_if.slave bus,
  output arb_state_t             dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
  localparam logic [STOCK_W-1:0] STOCK_RELOAD = STOCK_W'(STOCK_INIT);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] nak_q, nak_d;
  logic               motor_on_q, motor_on_d;
  logic               busy_q, busy_d;
  logic [STOCK_W-1:0] stock_q, stock_d;
  logic               sold_out_q, sold_out_d;

  logic [NUM_REQ-1:0] req_eff;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  // A refused requester still holds req while nak is visible; mask it so it
  // is not refused twice.
  assign req_eff = bus.req & ~nak_q;

  vend_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_eff),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    ack_d      = '0;
    nak_d      = '0;
    motor_on_d = 1'b0;
    stock_d    = stock_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_idx;
          if (stock_q != '0) begin
            state_d = GRANT;
          end else begin
            nak_d[pick_idx] = 1'b1;
            rr_ptr_d        = IDX_W'(wrap_inc(32'(pick_idx), NUM_REQ));
          end
        end
      end
      GRANT: begin
        cnt_d      = CNT_W'(MOTOR_CYCLES - 1);
        motor_on_d = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (cnt_q == '0) begin
          ack_d[grant_id_q] = 1'b1;
          state_d           = DONE;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          motor_on_d = 1'b1;
        end
      end
      DONE: begin
        if (stock_q != '0) stock_d = stock_q - STOCK_W'(1);
        rr_ptr_d = IDX_W'(wrap_inc(32'(grant_id_q), NUM_REQ));
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Restock overrides the DONE decrement
    if (bus.restock) stock_d = STOCK_RELOAD;
    busy_d     = (state_d != IDLE);
    sold_out_d = (stock_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      ack_q      <= '0;
      nak_q      <= '0;
      motor_on_q <= 1'b0;
      busy_q     <= 1'b0;
      stock_q    <= STOCK_RELOAD;
      sold_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      ack_q      <= ack_d;
      nak_q      <= nak_d;
      motor_on_q <= motor_on_d;
      busy_q     <= busy_d;
      stock_q    <= stock_d;
      sold_out_q <= sold_out_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.nak      = nak_q;
  assign bus.motor_on = motor_on_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;
  assign bus.stock    = stock_q;
  assign bus.sold_out = sold_out_q;
  assign dbg_state    = state_q;

endmodule
